// File: rtl/game_flow_pkg.sv
// Shared types and constants for the game session sequencer: state encoding,
// speed limits, elapsed-time saturation and stage-clear dwell.
package game_flow_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNTDOWN,
    ST_PLAY,
    ST_PAUSE,
    ST_STAGE_CLEAR,
    ST_GAME_OVER,
    ST_WIN
  } state_t;

  localparam logic [3:0] SPEED_EASY        = 4'd1;
  localparam logic [3:0] SPEED_HARD        = 4'd4;
  localparam logic [3:0] SPEED_MAX         = 4'd15;
  localparam logic [9:0] ELAPSED_MAX       = 10'd999;
  localparam logic [1:0] STAGE_CLEAR_TICKS = 2'd2;
  localparam logic [1:0] COUNTDOWN_START   = 2'd3;

  function automatic logic [3:0] base_speed(input logic hard);
    return hard ? SPEED_HARD : SPEED_EASY;
  endfunction

  // Stage-mode speed: base + stage - 1, clamped to the datapath maximum.
  function automatic logic [3:0] stage_speed(input logic hard, input logic [2:0] stage);
    logic [4:0] sum;
    sum = {1'b0, base_speed(hard)} + {2'b00, stage} - 5'd1;
    return (sum > {1'b0, SPEED_MAX}) ? SPEED_MAX : sum[3:0];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Game tick divider: emits a one-cycle tick every TICK_CYCLES enabled cycles.
// A clear restarts the interval, counting the clear cycle as its first cycle.
module tick_gen #(
  parameter int TICK_CYCLES = 100_000_000
) (
  input  logic clock_100mhz,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // The count is stale during a clear cycle, so the tick is masked there.
  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CW'(1);
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Session sequencer: countdown, play, stage progression / endless speed-up and
// end screens. Define GAME_FLOW_PAUSE_EN to enable the PAUSE state.
module game_flow_ctrl #(
  parameter int TICK_CYCLES   = 100_000_000,
  parameter int NUM_STAGES    = 3,
  parameter int SPEEDUP_TICKS = 10
) (
  input  logic       clock_100mhz,
  input  logic       reset,
  input  logic       start_game,
  input  logic       mode,
  input  logic       difficulty,
  input  logic       crash,
  input  logic       stage_clear,
  input  logic       btn_confirm,
  input  logic       btn_pause,
  output logic       game_active,
  output logic       run_en,
  output logic [1:0] countdown_val,
  output logic [2:0] stage_num,
  output logic [3:0] speed_level,
  output logic [9:0] elapsed_s,
  output logic       result_win,
  output logic       paused,
  output logic [2:0] state_dbg
);

  import game_flow_pkg::*;

  localparam int SW = (SPEEDUP_TICKS > 1) ? $clog2(SPEEDUP_TICKS + 1) : 1;

  state_t        state;
  logic          start_d;
  logic          mode_r;
  logic          hard_r;
  logic          tick_clear;
  logic          tick_en;
  logic          tick;
  logic          end_armed;
  logic [1:0]    dwell_cnt;
  logic [SW-1:0] speed_cnt;

  assign tick_en   = !paused;
  assign state_dbg = state;

`ifndef GAME_FLOW_PAUSE_EN
  logic pause_unused;
  assign pause_unused = btn_pause;
`endif

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clock_100mhz(clock_100mhz),
    .reset       (reset),
    .clear       (tick_clear),
    .enable      (tick_en),
    .tick        (tick)
  );

  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      start_d       <= 1'b0;
      mode_r        <= 1'b0;
      hard_r        <= 1'b0;
      tick_clear    <= 1'b0;
      end_armed     <= 1'b0;
      dwell_cnt     <= '0;
      speed_cnt     <= '0;
      game_active   <= 1'b0;
      run_en        <= 1'b0;
      countdown_val <= '0;
      stage_num     <= 3'd1;
      speed_level   <= '0;
      elapsed_s     <= '0;
      result_win    <= 1'b0;
      paused        <= 1'b0;
    end else begin
      start_d    <= start_game;
      tick_clear <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_game && !start_d) begin
            state         <= ST_COUNTDOWN;
            tick_clear    <= 1'b1;
            mode_r        <= mode;
            hard_r        <= difficulty;
            stage_num     <= 3'd1;
            elapsed_s     <= '0;
            speed_level   <= base_speed(difficulty);
            speed_cnt     <= '0;
            game_active   <= 1'b1;
            countdown_val <= COUNTDOWN_START;
            result_win    <= 1'b0;
          end
        end
        ST_COUNTDOWN: begin
          if (tick) begin
            if (countdown_val == 2'd1) begin
              state         <= ST_PLAY;
              tick_clear    <= 1'b1;
              countdown_val <= '0;
              run_en        <= 1'b1;
            end else begin
              countdown_val <= countdown_val - 2'd1;
            end
          end
        end
        ST_PLAY: begin
          if (crash) begin
            state      <= ST_GAME_OVER;
            tick_clear <= 1'b1;
            run_en     <= 1'b0;
            end_armed  <= 1'b0;
          end else if (stage_clear && !mode_r) begin
            tick_clear <= 1'b1;
            run_en     <= 1'b0;
            if (stage_num < 3'(NUM_STAGES)) begin
              state     <= ST_STAGE_CLEAR;
              dwell_cnt <= '0;
            end else begin
              state      <= ST_WIN;
              result_win <= 1'b1;
              end_armed  <= 1'b0;
            end
          end
`ifdef GAME_FLOW_PAUSE_EN
          else if (btn_pause) begin
            state  <= ST_PAUSE;
            run_en <= 1'b0;
            paused <= 1'b1;
          end
`endif
          // A tick landing on the exit cycle still counts as play time.
          if (tick) begin
            if (elapsed_s != ELAPSED_MAX) elapsed_s <= elapsed_s + 10'd1;
            if (mode_r) begin
              if (speed_cnt == SW'(SPEEDUP_TICKS - 1)) begin
                speed_cnt <= '0;
                if (speed_level != SPEED_MAX) speed_level <= speed_level + 4'd1;
              end else begin
                speed_cnt <= speed_cnt + 1'b1;
              end
            end
          end
        end
`ifdef GAME_FLOW_PAUSE_EN
        ST_PAUSE: begin
          if (btn_pause) begin
            state  <= ST_PLAY;
            run_en <= 1'b1;
            paused <= 1'b0;
          end
        end
`endif
        ST_STAGE_CLEAR: begin
          if (tick) begin
            if (dwell_cnt == STAGE_CLEAR_TICKS - 2'd1) begin
              state         <= ST_COUNTDOWN;
              tick_clear    <= 1'b1;
              stage_num     <= stage_num + 3'd1;
              speed_level   <= stage_speed(hard_r, stage_num + 3'd1);
              countdown_val <= COUNTDOWN_START;
            end else begin
              dwell_cnt <= dwell_cnt + 2'd1;
            end
          end
        end
        ST_GAME_OVER, ST_WIN: begin
          if (btn_confirm && end_armed) begin
            state       <= ST_IDLE;
            game_active <= 1'b0;
            result_win  <= 1'b0;
          end else if (tick) begin
            end_armed <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl with short ticks (10 cycles) and a
// 2-tick endless speed-up interval; expectations derive from tick arithmetic.
`timescale 1ns/1ps
module tb_game_flow_ctrl;
  import game_flow_pkg::*;

  localparam int TICK    = 10;
  localparam int SPEEDUP = 2;
  localparam int STAGES  = 3;

  logic       clock_100mhz = 1'b0;
  logic       reset        = 1'b1;
  logic       start_game   = 1'b0;
  logic       mode         = 1'b0;
  logic       difficulty   = 1'b0;
  logic       crash        = 1'b0;
  logic       stage_clear  = 1'b0;
  logic       btn_confirm  = 1'b0;
  logic       btn_pause    = 1'b0;
  logic       game_active;
  logic       run_en;
  logic [1:0] countdown_val;
  logic [2:0] stage_num;
  logic [3:0] speed_level;
  logic [9:0] elapsed_s;
  logic       result_win;
  logic       paused;
  logic [2:0] state_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [3:0] exp_q[$];

  game_flow_ctrl #(
    .TICK_CYCLES  (TICK),
    .NUM_STAGES   (STAGES),
    .SPEEDUP_TICKS(SPEEDUP)
  ) dut (
    .clock_100mhz (clock_100mhz),
    .reset        (reset),
    .start_game   (start_game),
    .mode         (mode),
    .difficulty   (difficulty),
    .crash        (crash),
    .stage_clear  (stage_clear),
    .btn_confirm  (btn_confirm),
    .btn_pause    (btn_pause),
    .game_active  (game_active),
    .run_en       (run_en),
    .countdown_val(countdown_val),
    .stage_num    (stage_num),
    .speed_level  (speed_level),
    .elapsed_s    (elapsed_s),
    .result_win   (result_win),
    .paused       (paused),
    .state_dbg    (state_dbg)
  );

  // Clock and watchdog
  always #5 clock_100mhz = ~clock_100mhz;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: every task leaves the bench 1 ns after a rising edge.
  task automatic wait_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clock_100mhz);
      #1;
    end
  endtask

  task automatic start_session(input logic m, input logic d);
    start_game = 1'b0;
    wait_cycles(2);
    start_game = 1'b1; mode = m; difficulty = d;
    wait_cycles(1);
    mode = ~m; difficulty = ~d;
    vec_cnt++; if (game_active !== 1'b1) begin err_cnt++; $display("FAIL start_active: got %0d expected 1", game_active); end
    vec_cnt++; if (countdown_val !== 2'd3) begin err_cnt++; $display("FAIL start_countdown: got %0d expected 3", countdown_val); end
  endtask

  task automatic end_session();
    wait_cycles(12);
    btn_confirm = 1'b1; wait_cycles(1); btn_confirm = 1'b0;
    vec_cnt++; if (game_active !== 1'b0) begin err_cnt++; $display("FAIL end_active: got %0d expected 0", game_active); end
    vec_cnt++; if (result_win !== 1'b0) begin err_cnt++; $display("FAIL end_win: got %0d expected 0", result_win); end
  endtask

  task automatic pulse_crash();
    crash = 1'b1; wait_cycles(1); crash = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    vec_cnt++; if (game_active !== 1'b0) begin err_cnt++; $display("FAIL rst_active: got %0d expected 0", game_active); end
    vec_cnt++; if (run_en !== 1'b0) begin err_cnt++; $display("FAIL rst_run: got %0d expected 0", run_en); end
    vec_cnt++; if (countdown_val !== 2'd0) begin err_cnt++; $display("FAIL rst_cd: got %0d expected 0", countdown_val); end
    vec_cnt++; if (stage_num !== 3'd1) begin err_cnt++; $display("FAIL rst_stage: got %0d expected 1", stage_num); end
    vec_cnt++; if (speed_level !== 4'd0) begin err_cnt++; $display("FAIL rst_speed: got %0d expected 0", speed_level); end
    vec_cnt++; if (elapsed_s !== 10'd0) begin err_cnt++; $display("FAIL rst_elapsed: got %0d expected 0", elapsed_s); end
    vec_cnt++; if ({result_win, paused} !== 2'b00) begin err_cnt++; $display("FAIL rst_flags: got %b expected 00", {result_win, paused}); end
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_countdown();
    start_session(1'b0, 1'b0);
    wait_cycles(TICK - 1);
    vec_cnt++; if (countdown_val !== 2'd3) begin err_cnt++; $display("FAIL cd_hold3: got %0d expected 3", countdown_val); end
    wait_cycles(1);
    vec_cnt++; if (countdown_val !== 2'd2) begin err_cnt++; $display("FAIL cd_2: got %0d expected 2", countdown_val); end
    wait_cycles(TICK);
    vec_cnt++; if (countdown_val !== 2'd1) begin err_cnt++; $display("FAIL cd_1: got %0d expected 1", countdown_val); end
    wait_cycles(TICK - 1);
    vec_cnt++; if (run_en !== 1'b0) begin err_cnt++; $display("FAIL cd_run_early: got %0d expected 0", run_en); end
    wait_cycles(1);
    vec_cnt++; if (run_en !== 1'b1) begin err_cnt++; $display("FAIL cd_run: got %0d expected 1", run_en); end
    vec_cnt++; if (countdown_val !== 2'd0) begin err_cnt++; $display("FAIL cd_0: got %0d expected 0", countdown_val); end
    vec_cnt++; if (speed_level !== 4'd1) begin err_cnt++; $display("FAIL cd_speed: got %0d expected 1", speed_level); end
    vec_cnt++; if (stage_num !== 3'd1) begin err_cnt++; $display("FAIL cd_stage: got %0d expected 1", stage_num); end
    pulse_crash();
    end_session();
  endtask

  task automatic test_stages();
    int m_elapsed = 0;
    logic [3:0] exp_speed;
    for (int s = 1; s <= STAGES; s++) exp_q.push_back(4'(4 + s - 1));
    start_session(1'b0, 1'b1);
    for (int s = 1; s <= STAGES; s++) begin
      int k, r;
      wait_cycles(3 * TICK);
      exp_speed = exp_q.pop_front();
      vec_cnt++; if (run_en !== 1'b1) begin err_cnt++; $display("FAIL stg_run s%0d: got %0d expected 1", s, run_en); end
      vec_cnt++; if (stage_num !== 3'(s)) begin err_cnt++; $display("FAIL stg_num: got %0d expected %0d", stage_num, s); end
      vec_cnt++; if (speed_level !== exp_speed) begin err_cnt++; $display("FAIL stg_speed: got %0d expected %0d", speed_level, exp_speed); end
      k = $urandom_range(0, 3);
      r = $urandom_range(1, 7);
      wait_cycles(k * TICK + r);
      m_elapsed += k;
      vec_cnt++; if (elapsed_s !== 10'(m_elapsed)) begin err_cnt++; $display("FAIL stg_elapsed: got %0d expected %0d", elapsed_s, m_elapsed); end
      stage_clear = 1'b1; wait_cycles(1); stage_clear = 1'b0;
      vec_cnt++; if (run_en !== 1'b0) begin err_cnt++; $display("FAIL stg_stop: got %0d expected 0", run_en); end
      if (s < STAGES) begin
        vec_cnt++; if (state_dbg !== ST_STAGE_CLEAR) begin err_cnt++; $display("FAIL stg_state: got %0d expected %0d", state_dbg, ST_STAGE_CLEAR); end
        wait_cycles(2 * TICK - 1);
        vec_cnt++; if (stage_num !== 3'(s)) begin err_cnt++; $display("FAIL stg_dwell: got %0d expected %0d", stage_num, s); end
        wait_cycles(1);
        vec_cnt++; if (stage_num !== 3'(s + 1)) begin err_cnt++; $display("FAIL stg_next: got %0d expected %0d", stage_num, s + 1); end
        vec_cnt++; if (countdown_val !== 2'd3) begin err_cnt++; $display("FAIL stg_cd: got %0d expected 3", countdown_val); end
      end else begin
        vec_cnt++; if (result_win !== 1'b1) begin err_cnt++; $display("FAIL stg_win: got %0d expected 1", result_win); end
        vec_cnt++; if (state_dbg !== ST_WIN) begin err_cnt++; $display("FAIL stg_win_state: got %0d expected %0d", state_dbg, ST_WIN); end
        vec_cnt++; if (game_active !== 1'b1) begin err_cnt++; $display("FAIL stg_win_active: got %0d expected 1", game_active); end
      end
    end
    end_session();
  endtask

  task automatic test_endless();
    int a, m, ticks, exp_spd;
    start_session(1'b1, 1'b0);
    wait_cycles(3 * TICK);
    a = $urandom_range(3, 30);
    wait_cycles(a);
    stage_clear = 1'b1; wait_cycles(1); stage_clear = 1'b0;
    wait_cycles(40 - a - 1);
    vec_cnt++; if (run_en !== 1'b1) begin err_cnt++; $display("FAIL end_run: got %0d expected 1", run_en); end
    vec_cnt++; if (speed_level !== 4'd3) begin err_cnt++; $display("FAIL endless_speed40: got %0d expected 3", speed_level); end
    vec_cnt++; if (elapsed_s !== 10'd4) begin err_cnt++; $display("FAIL endless_elapsed40: got %0d expected 4", elapsed_s); end
    m = $urandom_range(1, 60);
    wait_cycles(m);
    ticks = (40 + m) / TICK;
    exp_spd = (1 + ticks / SPEEDUP > 15) ? 15 : 1 + ticks / SPEEDUP;
    vec_cnt++; if (elapsed_s !== 10'(ticks)) begin err_cnt++; $display("FAIL endless_elapsed: got %0d expected %0d", elapsed_s, ticks); end
    vec_cnt++; if (speed_level !== 4'(exp_spd)) begin err_cnt++; $display("FAIL endless_speed: got %0d expected %0d", speed_level, exp_spd); end
    pulse_crash();
    vec_cnt++; if (run_en !== 1'b0) begin err_cnt++; $display("FAIL endless_crash_run: got %0d expected 0", run_en); end
    vec_cnt++; if (state_dbg !== ST_GAME_OVER) begin err_cnt++; $display("FAIL endless_crash_state: got %0d expected %0d", state_dbg, ST_GAME_OVER); end
    end_session();
  endtask

  task automatic test_saturation();
    int n, ticks;
    start_session(1'b1, 1'b1);
    wait_cycles(3 * TICK);
    n = $urandom_range(230, 300);
    wait_cycles(n);
    ticks = n / TICK;
    vec_cnt++; if (speed_level !== 4'd15) begin err_cnt++; $display("FAIL sat_speed: got %0d expected 15", speed_level); end
    vec_cnt++; if (elapsed_s !== 10'(ticks)) begin err_cnt++; $display("FAIL sat_elapsed_mid: got %0d expected %0d", elapsed_s, ticks); end
    wait_cycles(10050 - n);
    vec_cnt++; if (elapsed_s !== 10'd999) begin err_cnt++; $display("FAIL sat_elapsed: got %0d expected 999", elapsed_s); end
    pulse_crash();
    end_session();
  endtask

  task automatic test_crash_priority();
    logic d;
    d = 1'($urandom_range(0, 1));
    start_session(1'b0, d);
    wait_cycles(3 * TICK + $urandom_range(1, 8));
    crash = 1'b1; stage_clear = 1'b1;
    wait_cycles(1);
    crash = 1'b0; stage_clear = 1'b0;
    vec_cnt++; if (state_dbg !== ST_GAME_OVER) begin err_cnt++; $display("FAIL prio_state: got %0d expected %0d", state_dbg, ST_GAME_OVER); end
    vec_cnt++; if (stage_num !== 3'd1) begin err_cnt++; $display("FAIL prio_stage: got %0d expected 1", stage_num); end
    vec_cnt++; if ({run_en, result_win} !== 2'b00) begin err_cnt++; $display("FAIL prio_flags: got %b expected 00", {run_en, result_win}); end
  endtask

  // Continues from the GAME_OVER entered by test_crash_priority, start_game still high.
  task automatic test_confirm();
    wait_cycles($urandom_range(0, 8));
    btn_confirm = 1'b1; wait_cycles(1); btn_confirm = 1'b0;
    vec_cnt++; if (game_active !== 1'b1) begin err_cnt++; $display("FAIL conf_early: got %0d expected 1", game_active); end
    wait_cycles(12);
    btn_confirm = 1'b1; wait_cycles(1); btn_confirm = 1'b0;
    vec_cnt++; if (game_active !== 1'b0) begin err_cnt++; $display("FAIL conf_late: got %0d expected 0", game_active); end
    vec_cnt++; if (state_dbg !== ST_IDLE) begin err_cnt++; $display("FAIL conf_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    wait_cycles(20);
    vec_cnt++; if (game_active !== 1'b0) begin err_cnt++; $display("FAIL conf_held_start: got %0d expected 0", game_active); end
  endtask

  task automatic test_reset_mid();
    start_session(1'b0, 1'b0);
    wait_cycles(3 * TICK + $urandom_range(1, 20));
    vec_cnt++; if (run_en !== 1'b1) begin err_cnt++; $display("FAIL rmid_run: got %0d expected 1", run_en); end
    #3 reset = 1'b1;
    #1;
    vec_cnt++; if ({game_active, run_en, result_win, paused} !== 4'b0000) begin err_cnt++; $display("FAIL rmid_flags: got %b expected 0000", {game_active, run_en, result_win, paused}); end
    vec_cnt++; if ({countdown_val, stage_num, speed_level} !== {2'd0, 3'd1, 4'd0}) begin err_cnt++; $display("FAIL rmid_fields: got %h expected %h", {countdown_val, stage_num, speed_level}, {2'd0, 3'd1, 4'd0}); end
    vec_cnt++; if (elapsed_s !== 10'd0) begin err_cnt++; $display("FAIL rmid_elapsed: got %0d expected 0", elapsed_s); end
    start_game = 1'b0;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(3);
    vec_cnt++; if (game_active !== 1'b0) begin err_cnt++; $display("FAIL rmid_release: got %0d expected 0", game_active); end
  endtask

  task automatic test_pause();
    start_session(1'b0, 1'b0);
    wait_cycles(3 * TICK);
`ifdef GAME_FLOW_PAUSE_EN
    begin
      int r;
      r = $urandom_range(2, 6);
      wait_cycles(r);
      btn_pause = 1'b1; wait_cycles(1); btn_pause = 1'b0;
      vec_cnt++; if ({paused, run_en} !== 2'b10) begin err_cnt++; $display("FAIL pause_enter: got %b expected 10", {paused, run_en}); end
      pulse_crash();
      wait_cycles(49);
      vec_cnt++; if (elapsed_s !== 10'd0) begin err_cnt++; $display("FAIL pause_frozen: got %0d expected 0", elapsed_s); end
      vec_cnt++; if (state_dbg !== ST_PAUSE) begin err_cnt++; $display("FAIL pause_state: got %0d expected %0d", state_dbg, ST_PAUSE); end
      btn_pause = 1'b1; wait_cycles(1); btn_pause = 1'b0;
      vec_cnt++; if ({paused, run_en} !== 2'b01) begin err_cnt++; $display("FAIL pause_resume: got %b expected 01", {paused, run_en}); end
      wait_cycles(8 - r);
      vec_cnt++; if (elapsed_s !== 10'd0) begin err_cnt++; $display("FAIL pause_pre_tick: got %0d expected 0", elapsed_s); end
      wait_cycles(1);
      vec_cnt++; if (elapsed_s !== 10'd1) begin err_cnt++; $display("FAIL pause_tick: got %0d expected 1", elapsed_s); end
    end
`else
    wait_cycles($urandom_range(1, 8));
    btn_pause = 1'b1; wait_cycles(1); btn_pause = 1'b0;
    vec_cnt++; if ({paused, run_en} !== 2'b01) begin err_cnt++; $display("FAIL nopause: got %b expected 01", {paused, run_en}); end
    vec_cnt++; if (state_dbg !== ST_PLAY) begin err_cnt++; $display("FAIL nopause_state: got %0d expected %0d", state_dbg, ST_PLAY); end
`endif
    pulse_crash();
    end_session();
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_countdown();
    test_stages();
    test_endless();
    test_saturation();
    test_crash_priority();
    test_confirm();
    test_reset_mid();
    test_pause();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Session sequencer between the menu and the gameplay datapath. It picks up the menu's start request, latches mode and difficulty, and runs the countdown. It then sequences play, stage progression, or endless speed-up, and the end-of-game screens. It drives `game_active`, which releases the menu back to its home page when the session ends.

## Interface
- `TICK_CYCLES`, 100_000_000: clock cycles per game tick (1 s at 100 MHz).
- `NUM_STAGES`, 3: number of stages in stage mode (1..7).
- `SPEEDUP_TICKS`, 10: ticks between speed increments in endless mode.
- `clock_100mhz`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start_game`, in, 1: level from the menu; a session starts on its rising edge.
- `mode`, in, 1: 0 = stage, 1 = endless. Sampled with `start_game`.
- `difficulty`, in, 1: 0 = easy, 1 = hard. Sampled with `start_game`.
- `crash`, in, 1: single-cycle pulse from the gameplay datapath.
- `stage_clear`, in, 1: single-cycle pulse marking the end of a stage.
- `btn_confirm`, in, 1: debounced single-cycle pulse (centre button).
- `btn_pause`, in, 1: debounced single-cycle pulse (used only with `GAME_FLOW_PAUSE_EN`).
- `game_active`, out, 1: high from session start until the player confirms on an end screen.
- `run_en`, out, 1: gameplay datapath may advance.
- `countdown_val`, out, 2: 3/2/1 during the countdown, otherwise 0.
- `stage_num`, out, 3: current stage, 1-based.
- `speed_level`, out, 4: speed setting for the datapath.
- `elapsed_s`, out, 10: ticks spent in PLAY; saturates at 999.
- `result_win`, out, 1: high in WIN.
- `paused`, out, 1: high in PAUSE.

## Operation
- **States:** IDLE, COUNTDOWN, PLAY, PAUSE, STAGE_CLEAR, GAME_OVER, WIN.
- **Reset values:** state = IDLE. All outputs 0, except `stage_num` = 1 and `speed_level` = 0.
- **IDLE → COUNTDOWN:** on a rising edge of `start_game` (compare against a registered copy of the previous value).
  - Latch `mode` and `difficulty`.
  - Set `stage_num` = 1, `elapsed_s` = 0.
  - Set `speed_level` = base, where base = 1 for easy and 4 for hard.
- **COUNTDOWN:** `countdown_val` shows 3, then 2, then 1, one tick each; after 3 ticks → PLAY. `crash` and `stage_clear` are ignored.
- **PLAY:** `run_en` = 1; `elapsed_s` increments each tick.
  - Stage mode: `speed_level` = base + `stage_num` − 1.
  - Endless mode: `speed_level` increments every `SPEEDUP_TICKS` ticks and saturates at 15.
- **`crash` in PLAY:** → GAME_OVER.
- **`stage_clear` in PLAY, stage mode:**
  - If `stage_num` < `NUM_STAGES`: → STAGE_CLEAR.
  - Otherwise: → WIN.
  - In endless mode `stage_clear` is ignored.
- **Simultaneous `crash` and `stage_clear`:** `crash` wins.
- **STAGE_CLEAR:** `run_en` = 0. Hold for 2 ticks, increment `stage_num`, then → COUNTDOWN.
- **GAME_OVER / WIN:**
  - `run_en` = 0; `game_active` stays 1.
  - `btn_confirm` is ignored during the first tick after entry.
  - After that, `btn_confirm` → IDLE.
- A new `start_game` edge outside IDLE is ignored.

## Timing
- Tick counter clears on every state entry, so each timed interval is exactly N × `TICK_CYCLES` cycles from entry.
- `game_active` rises 1 cycle after the sampled `start_game` edge.
- `countdown_val` = 3 is valid in the same cycle as `game_active`.
- COUNTDOWN → PLAY occurs exactly 3 × `TICK_CYCLES` cycles after COUNTDOWN entry.
- All outputs are registered. `run_en` falls in the cycle after the `crash` pulse.
- `btn_confirm` in GAME_OVER/WIN: `game_active` is 0 on the next cycle.
- `reset` mid-session forces IDLE and reset values immediately (asynchronous assertion, synchronous release).
- `elapsed_s` and `speed_level` never wrap; both saturate.

## Configuration
- `GAME_FLOW_PAUSE_EN` defined:
  - `btn_pause` in PLAY → PAUSE. `run_en` = 0, `paused` = 1; tick counter and `elapsed_s` freeze.
  - `btn_pause` in PAUSE → PLAY, resuming the tick count where it stopped.
  - `crash` and `stage_clear` are ignored in PAUSE.
- Undefined: PAUSE is unreachable, `btn_pause` is ignored, and `paused` is tied to 0.

## Structure
- **`game_flow_pkg`:** state enum, base speed constants (easy 1, hard 4), max speed 15, elapsed-time saturation value 999, STAGE_CLEAR dwell (2 ticks).
- **Sub-module `tick_gen`:** counts to `TICK_CYCLES` and emits a single-cycle `tick` pulse. It has a synchronous `clear` and an `enable` (the enable is used for pause).

## Test plan
Run the bench with `TICK_CYCLES` = 10 and `SPEEDUP_TICKS` = 2.
1. Reset, then `start_game` rises with mode 0, difficulty 0 → `game_active` = 1 next cycle. `countdown_val` reads 3, 2, 1 at 10-cycle steps. `run_en` = 1 at cycle 31, `speed_level` = 1.
2. Stage mode, hard, with `NUM_STAGES` = 3: three `stage_clear` pulses → `stage_num` goes 1, 2, 3 and `speed_level` goes 4, 5, 6. The third pulse gives WIN with `result_win` = 1.
3. Endless, easy: 40 PLAY cycles → `speed_level` = 3, `elapsed_s` = 4. A `stage_clear` pulse has no effect. Then `crash` → `run_en` = 0 on the next cycle, GAME_OVER.
4. `crash` and `stage_clear` in the same cycle in stage mode → GAME_OVER, `stage_num` unchanged.
5. GAME_OVER: `btn_confirm` within 10 cycles of entry is ignored. A later `btn_confirm` → `game_active` = 0 on the next cycle. `start_game` held high does not restart the session without a new rising edge.
6. `reset` asserted in PLAY → all outputs at reset values in the same cycle. With `GAME_FLOW_PAUSE_EN`: pause for 50 cycles → `elapsed_s` unchanged across the pause.
